// File: rtl/led_rgb_status_pwm.sv
// led_rgb_status_pwm
// Registered, dimmable RGB status indicator for the calculator result display.
// Green shows a valid result, red shows an error. Both colours are PWM-dimmed,
// the error colour additionally blinks, and the error verdict stays latched
// for as long as the calculator remains in its result-display state.
//
// Handshake: none. error and estado are plain levels sampled on every clk
// edge; out is a registered level that follows them two edges later.
module led_rgb_status_pwm #(
    parameter int                 STATE_W    = 2,
    parameter logic [STATE_W-1:0] SHOW_STATE = STATE_W'(3),
    parameter int                 PWM_W      = 8,
    parameter int                 DUTY       = 64,
    parameter int                 BLINK_HALF = 12_500_000,
    parameter logic [2:0]         COLOR_OK   = 3'b010,
    parameter logic [2:0]         COLOR_ERR  = 3'b100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               error,
    input  logic [STATE_W-1:0] estado,
    output logic [2:0]         out
);

    // A blink half-period of one cycle still needs a one-bit counter.
    localparam int                 BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [PWM_W-1:0]   DUTY_V     = PWM_W'(DUTY);
    // An all-ones duty means "always on"; a plain compare would drop one cycle.
    localparam logic               DUTY_FULL  = (DUTY == (2 ** PWM_W) - 1);

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_OK  = 2'd1,
        ST_ERR = 2'd2
    } state_t;

    state_t             state;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic               pwm_on;
    logic               showing;

    assign showing = (estado == SHOW_STATE);

    // PWM gate derived from the current counter value.
    always_comb begin
        pwm_on = 1'b0;
        if (DUTY_FULL) begin
            pwm_on = 1'b1;
        end else begin
            pwm_on = (pwm_cnt < DUTY_V);
        end
    end

    // Free-running PWM counter; only reset_n restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Result-state FSM with the blink timer; leaving ERR or entering it
    // always leaves the timer at the start of a lit phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_OFF;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    blink_cnt <= '0;
                    blink_on  <= 1'b1;
                    if (showing) begin
                        state <= error ? ST_ERR : ST_OK;
                    end
                end
                ST_OK: begin
                    blink_cnt <= '0;
                    blink_on  <= 1'b1;
                    // Leaving the display state wins over a rising error.
                    if (!showing) begin
                        state <= ST_OFF;
                    end else if (error) begin
                        state <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    // Error is sticky: only leaving the display state exits.
                    if (!showing) begin
                        state     <= ST_OFF;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    blink_cnt <= '0;
                    blink_on  <= 1'b1;
                end
            endcase
        end
    end

    // LED drive register, loaded every edge from the pre-edge state and gates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= 3'b000;
        end else begin
            case (state)
                ST_OK:   out <= COLOR_OK & {3{pwm_on}};
                ST_ERR:  out <= COLOR_ERR & {3{pwm_on & blink_on}};
                default: out <= 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_led_rgb_status_pwm.sv
// tb_led_rgb_status_pwm
// Directed checks of the RGB status indicator with PWM_W=3, BLINK_HALF=5 and
// three duty settings (4, 0 and 7) driven from the same inputs.
module tb_led_rgb_status_pwm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       error = 1'b0;
    logic [1:0] estado = 2'd0;
    logic [2:0] out;
    logic [2:0] out_d0;
    logic [2:0] out_d7;

    int tests_run = 0;
    int tests_failed = 0;
    // Edges since the last reset release; pwm_cnt after edge k equals k mod 8.
    int n = 0;

    // clock
    always #5 clk = ~clk;

    led_rgb_status_pwm #(.STATE_W(2), .SHOW_STATE(2'd3), .PWM_W(3), .DUTY(4), .BLINK_HALF(5),
                         .COLOR_OK(3'b010), .COLOR_ERR(3'b100)) dut (
        .clk(clk), .reset_n(reset_n), .error(error), .estado(estado), .out(out));

    led_rgb_status_pwm #(.STATE_W(2), .SHOW_STATE(2'd3), .PWM_W(3), .DUTY(0), .BLINK_HALF(5),
                         .COLOR_OK(3'b010), .COLOR_ERR(3'b100)) dut_d0 (
        .clk(clk), .reset_n(reset_n), .error(error), .estado(estado), .out(out_d0));

    led_rgb_status_pwm #(.STATE_W(2), .SHOW_STATE(2'd3), .PWM_W(3), .DUTY(7), .BLINK_HALF(5),
                         .COLOR_OK(3'b010), .COLOR_ERR(3'b100)) dut_d7 (
        .clk(clk), .reset_n(reset_n), .error(error), .estado(estado), .out(out_d7));

    // Advance one edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset_n) n++;
    endtask

    // Out after edge k used pwm_cnt = (k-1) mod 8 before that edge.
    function automatic bit pwm_lit(int k);
        return ((k - 1) % 8) < 4;
    endfunction

    // blink_on after edge k, ERR entered at edge e: lit in even 5-cycle phases.
    function automatic bit blink_lit(int k, int e);
        return (((k - e) / 5) % 2) == 0;
    endfunction

    function automatic logic [2:0] exp_err(int k, int e);
        return (pwm_lit(k) && blink_lit(k - 1, e)) ? 3'b100 : 3'b000;
    endfunction

    function automatic logic [2:0] exp_ok(int k);
        return pwm_lit(k) ? 3'b010 : 3'b000;
    endfunction

    task automatic test_reset();
        estado = 2'd3;
        error  = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (out !== 3'b000 || out_d0 !== 3'b000 || out_d7 !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_async: got %b/%b/%b expected 000", out, out_d0, out_d7);
        end
        repeat (3) step();
        tests_run++;
        if (out !== 3'b000 || out_d7 !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b/%b expected 000", out, out_d7);
        end
        reset_n = 1'b1;
        n = 0;
        step();
        tests_run++;
        if (out !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_rel_edge1: got %b expected 000", out);
        end
        step();
        tests_run++;
        if (out !== 3'b100 || out_d7 !== 3'b100 || out_d0 !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_rel_edge2: got %b/%b/%b expected 100/100/000", out, out_d7, out_d0);
        end
    endtask

    task automatic test_err_blink();
        logic [2:0] exp_v;
        // ERR was entered on edge 1 after release.
        for (int i = 0; i < 20; i++) begin
            step();
            exp_v = exp_err(n, 1);
            tests_run++;
            if (out !== exp_v) begin
                tests_failed++;
                $display("FAIL err_blink n=%0d: got %b expected %b", n, out, exp_v);
            end
        end
    endtask

    task automatic test_ok_dimming();
        logic [2:0] exp_v;
        int lit;
        lit = 0;
        estado = 2'd0;
        step();
        step();
        tests_run++;
        if (out !== 3'b000) begin
            tests_failed++;
            $display("FAIL ok_leave_err: got %b expected 000", out);
        end
        estado = 2'd3;
        error  = 1'b0;
        step();
        tests_run++;
        if (out !== 3'b000) begin
            tests_failed++;
            $display("FAIL ok_entry_latency: got %b expected 000", out);
        end
        for (int i = 0; i < 32; i++) begin
            step();
            exp_v = exp_ok(n);
            if (out === 3'b010) lit++;
            tests_run++;
            if (out !== exp_v) begin
                tests_failed++;
                $display("FAIL ok_dim n=%0d: got %b expected %b", n, out, exp_v);
            end
        end
        tests_run++;
        if (lit != 16) begin
            tests_failed++;
            $display("FAIL ok_duty_count: got %0d lit cycles expected 16", lit);
        end
    endtask

    task automatic test_sticky_upgrade();
        logic [2:0] exp_v;
        int e;
        error = 1'b1;
        e = n + 1;
        step();
        exp_v = exp_ok(n);
        tests_run++;
        if (out !== exp_v) begin
            tests_failed++;
            $display("FAIL upgrade_edge: got %b expected %b", out, exp_v);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            exp_v = exp_err(n, e);
            tests_run++;
            if (out !== exp_v) begin
                tests_failed++;
                $display("FAIL upgrade_err n=%0d: got %b expected %b", n, out, exp_v);
            end
        end
        error = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_v = exp_err(n, e);
            tests_run++;
            if (out !== exp_v) begin
                tests_failed++;
                $display("FAIL sticky n=%0d: got %b expected %b", n, out, exp_v);
            end
        end
        estado = 2'd0;
        step();
        exp_v = exp_err(n, e);
        tests_run++;
        if (out !== exp_v) begin
            tests_failed++;
            $display("FAIL sticky_exit_edge1: got %b expected %b", out, exp_v);
        end
        step();
        tests_run++;
        if (out !== 3'b000) begin
            tests_failed++;
            $display("FAIL sticky_exit_edge2: got %b expected 000", out);
        end
    endtask

    task automatic test_duty_bounds();
        logic [2:0] exp_v;
        estado = 2'd3;
        error  = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            exp_v = exp_ok(n);
            tests_run++;
            if (out_d0 !== 3'b000 || out_d7 !== 3'b010 || out !== exp_v) begin
                tests_failed++;
                $display("FAIL duty_bounds n=%0d: got d0=%b d7=%b d4=%b expected 000/010/%b",
                         n, out_d0, out_d7, out, exp_v);
            end
        end
        // Leave the display state on the same edge the error rises.
        estado = 2'd0;
        error  = 1'b1;
        step();
        exp_v = exp_ok(n);
        tests_run++;
        if (out !== exp_v || out_d7 !== 3'b010) begin
            tests_failed++;
            $display("FAIL race_edge1: got %b/%b expected %b/010", out, out_d7, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (out !== 3'b000 || out_d7 !== 3'b000) begin
                tests_failed++;
                $display("FAIL race_off n=%0d: got %b/%b expected 000", n, out, out_d7);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_v;
        int e;
        estado = 2'd3;
        error  = 1'b1;
        step();
        e = n;
        for (int i = 0; i < 10; i++) begin
            step();
            if (exp_err(n, e) == 3'b100) break;
        end
        tests_run++;
        if (out !== 3'b100) begin
            tests_failed++;
            $display("FAIL prepulse_lit: got %b expected 100", out);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out !== 3'b000 || out_d0 !== 3'b000 || out_d7 !== 3'b000) begin
            tests_failed++;
            $display("FAIL pulse_async: got %b/%b/%b expected 000", out, out_d0, out_d7);
        end
        #2 reset_n = 1'b1;
        n = 0;
        step();
        tests_run++;
        if (out !== 3'b000) begin
            tests_failed++;
            $display("FAIL pulse_rel_edge1: got %b expected 000", out);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            exp_v = exp_err(n, 1);
            tests_run++;
            if (out !== exp_v) begin
                tests_failed++;
                $display("FAIL pulse_reblink n=%0d: got %b expected %b", n, out, exp_v);
            end
            exp_v = blink_lit(n - 1, 1) ? 3'b100 : 3'b000;
            tests_run++;
            if (out_d7 !== exp_v) begin
                tests_failed++;
                $display("FAIL pulse_full_duty n=%0d: got %b expected %b", n, out_d7, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_err_blink();
        test_ok_dimming();
        test_sticky_upgrade();
        test_duty_bounds();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
